// File: rtl/vga_fb_reader.sv
// 640x480@60 VGA reader for a 320x240 RGB565 frame buffer, 2x2 pixel replication, 3-clk pipeline.
// Optional build macro VGA_FB_TEST_PATTERN_EN: show 8 vertical colour bars instead of frame-buffer data.
module vga_fb_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic        oe,
    output logic [16:0] rAddr,
    input  logic [15:0] rData,
    output logic        h_sync,
    output logic        v_sync,
    output logic        de,
    output logic [4:0]  red,
    output logic [5:0]  green,
    output logic [4:0]  blue,
    output logic        frame_start
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START  = H_ACTIVE + H_FP;
    localparam int HS_END    = HS_START + H_SYNC;
    localparam int VS_START  = V_ACTIVE + V_FP;
    localparam int VS_END    = VS_START + V_SYNC;

    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
        logic fs;
    } decode_t;

    localparam decode_t DECODE_RST = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    decode_t     dec_s0, dec1_q, dec2_q;
    logic        oe_q, oe_d;
    logic [16:0] raddr_q, raddr_d, addr_s0;
    logic [8:0]  src_x, src_y;
    logic        h_sync_q, v_sync_q, de_q, frame_start_q;
    logic [4:0]  red_q, red_d, blue_q, blue_d;
    logic [5:0]  green_q, green_d;

    // Stage 0: free-running raster counters and their decodes.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == 10'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        dec_s0.active = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
        dec_s0.hs_n   = !((h_cnt_q >= 10'(HS_START)) && (h_cnt_q < 10'(HS_END)));
        dec_s0.vs_n   = !((v_cnt_q >= 10'(VS_START)) && (v_cnt_q < 10'(VS_END)));
        dec_s0.fs     = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Source word = y*320 + x, built from shifts so no multiplier is needed.
    assign src_x   = h_cnt_q[9:1];
    assign src_y   = v_cnt_q[9:1];
    assign addr_s0 = {src_y, 8'b0} + {2'b0, src_y, 6'b0} + {8'b0, src_x};

    always_comb begin
        raddr_d = dec_s0.active ? addr_s0 : raddr_q;
`ifdef VGA_FB_TEST_PATTERN_EN
        oe_d = 1'b0;
`else
        oe_d = dec_s0.active;
`endif
    end

`ifdef VGA_FB_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] bar_s0, bar1_q, bar2_q;
    logic       unused_rdata;
    assign unused_rdata = ^rData;

    always_comb begin
        bar_s0 = '0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt_q >= 10'(k * BAR_W)) bar_s0 = bar_s0 + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar1_q <= '0;
            bar2_q <= '0;
        end else begin
            bar1_q <= bar_s0;
            bar2_q <= bar1_q;
        end
    end
`endif

    // Stage 3: colour is forced to black outside the visible window.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (dec2_q.active) begin
`ifdef VGA_FB_TEST_PATTERN_EN
            red_d   = {5{~bar2_q[1]}};
            green_d = {6{~bar2_q[2]}};
            blue_d  = {5{~bar2_q[0]}};
`else
            red_d   = rData[15:11];
            green_d = rData[10:5];
            blue_d  = rData[4:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            dec1_q        <= DECODE_RST;
            dec2_q        <= DECODE_RST;
            oe_q          <= 1'b0;
            raddr_q       <= '0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            dec1_q        <= dec_s0;
            dec2_q        <= dec1_q;
            oe_q          <= oe_d;
            raddr_q       <= raddr_d;
            h_sync_q      <= dec2_q.hs_n;
            v_sync_q      <= dec2_q.vs_n;
            de_q          <= dec2_q.active;
            frame_start_q <= dec2_q.fs;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign oe          = oe_q;
    assign rAddr       = raddr_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Display-side reader for the 320×240 RGB565 frame buffer. It generates 640×480@60 VGA timing from a single 25 MHz pixel clock and issues frame-buffer read addresses with 2× pixel/line replication. It aligns the registered RAM read data with the sync and data-enable outputs. It drives the frame buffer's read port and the board's VGA DAC pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock, 25 MHz; also the frame buffer's rclk
- reset  in  1  asynchronous, active-high
- oe  out  1  frame-buffer read enable
- rAddr  out  17  frame-buffer read address, 0..76799
- rData  in  16  RGB565 from the frame buffer, valid one clk after oe/rAddr
- h_sync  out  1  active-low horizontal sync
- v_sync  out  1  active-low vertical sync
- de  out  1  active-high display enable
- red  out  5  red channel (rData[15:11])
- green  out  6  green channel (rData[10:5])
- blue  out  5  blue channel (rData[4:0])
- frame_start  out  1  one-clk pulse aligned with pixel (0,0) on the pins

## Operation
- Stage 0 (counters):
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800, and wraps to 0.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1 (V_TOTAL = 525), then wraps to 0.
  - Active region is h_cnt<640 && v_cnt<480.
  - hsync is active for h_cnt in 656..751; vsync is active for v_cnt in 490..491.
- Stage 1 (address):
  - oe is registered from active.
  - rAddr is registered as (v_cnt>>1)*320 + (h_cnt>>1), computed as (y<<8)+(y<<6)+x with y=v_cnt[9:1] and x=h_cnt[9:1].
  - During blanking, rAddr holds its last value and oe=0.
- Stage 2: the frame buffer registers rData.
- Stage 3 (output registers):
  - red, green and blue are taken from rData when the delayed active flag is 1, and forced to 0 otherwise.
  - h_sync, v_sync, de and frame_start are taken from a 3-deep delay line of the stage-0 decodes.
- Each frame-buffer word is displayed as a 2×2 block. Each source line is read twice; the block has no line buffer.
- Reset values: counters 0; delay line cleared; oe 0, rAddr 0, h_sync 1, v_sync 1, de 0, red/green/blue 0, frame_start 0.
- Reset asserted mid-frame:
  - All outputs go to their reset values immediately (asynchronously).
  - After release, timing restarts at (0,0).
  - No partial-frame state is retained.

## Timing
- Latency from counter (h,v) to the pins is 3 clk. Pixel (h,v) appears on red/green/blue in the same cycle as its de=1.
- The first de=1 after reset release occurs on the 3rd rising edge after release, with frame_start=1 and data from rAddr 0.
- Line period is 800 clk; frame period is 420000 clk.
- de is high 640 clk per line on lines 0..479.
- h_sync is low 96 clk per line. Its falling edge comes 656 clk after the line's first de.
- v_sync is low for 1600 clk per frame, starting 490 lines after frame_start.
- v_sync transitions coincide with the h_cnt=0 stage-0 edge, delayed 3 clk.
- oe and rAddr change only on clk; they are never combinational from inputs.

## Configuration
- Macro VGA_FB_TEST_PATTERN_EN.
- Defined:
  - oe is held 0 and rData is ignored.
  - red/green/blue during active output 8 vertical colour bars, each 80 pixels wide: white, yellow, cyan, green, magenta, red, blue, black.
  - Colour levels are full-scale RGB565, e.g. white = 5'h1F/6'h3F/5'h1F.
  - All timing and latency are unchanged.
- Undefined: frame-buffer data is displayed as described in Operation.

## Test plan
- **Reset release:** assert reset for 5 clk, then release.
  - h_sync/v_sync stay 1, de 0, rgb 0 during reset.
  - The first frame_start and de=1 occur on edge 3 after release.
  - The first h_sync=0 occurs on edge 659.
- **Address map** (RAM model preloaded mem[k]=k[15:0]):
  - Pixel (0,0) shows 16'h0000 and pixel (1,1) also shows 16'h0000.
  - Pixel (2,3) shows 321.
  - Pixel (639,479) shows 76799[15:0] = 16'h2BFF.
  - rAddr never exceeds 76799.
- **Blanking:**
  - Over a full frame, de=1 on exactly 307200 clk.
  - red/green/blue are 0 whenever de=0, including when the RAM model drives 16'hFFFF.
  - oe=0 throughout blanking.
- **Frame timing:**
  - Consecutive frame_start pulses are 420000 clk apart.
  - v_sync is low for exactly 1600 contiguous clk per frame.
  - h_sync is low 96 clk every 800 clk.
- **Mid-frame reset:** assert reset at h=300, v=200 for 2 clk.
  - Outputs take their reset values within the same cycle.
  - The next frame_start comes 3 clk after release.
  - The next frame_start follows after a further 420000 clk.
- **VGA_FB_TEST_PATTERN_EN defined:**
  - oe is constant 0.
  - Pixel x=0 shows 1F/3F/1F; x=80 shows 1F/3F/00; x=560 shows 00/00/00.
  - The sync timing checks above all pass unchanged.
